// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions for the data-memory responder: memory operation
// codes, response FSM states and store lane formatting.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MT_NOP  = 3'b000,
    MT_W    = 3'b001,
    MT_LDB  = 3'b010,
    MT_LDH  = 3'b011,
    MT_LDBU = 3'b100,
    MT_LDHU = 3'b101,
    MT_STB  = 3'b110,
    MT_STH  = 3'b111
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_HOLD = 2'b10
  } resp_state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } store_lane_t;

  function automatic logic is_load_type(input mem_type_e kind);
    return (kind == MT_W) || (kind == MT_LDB) || (kind == MT_LDH) ||
           (kind == MT_LDBU) || (kind == MT_LDHU);
  endfunction

  function automatic logic is_store_type(input mem_type_e kind);
    return (kind == MT_W) || (kind == MT_STB) || (kind == MT_STH);
  endfunction

  // Byte accesses are always aligned; halves need an even address, words a
  // multiple of four.
  function automatic logic is_misaligned(input mem_type_e kind, input logic [1:0] off);
    logic mis;
    case (kind)
      MT_LDH, MT_LDHU, MT_STH: mis = off[0];
      MT_W:                    mis = (off != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic store_lane_t store_lane(input mem_type_e kind, input logic [1:0] off,
                                             input logic [31:0] wdata);
    store_lane_t lane;
    lane.be   = 4'b0000;
    lane.data = wdata;
    case (kind)
      MT_STB: begin
        lane.be   = 4'b0001 << off;
        lane.data = wdata << {off, 3'b000};
      end
      MT_STH: begin
        lane.be   = off[1] ? 4'b1100 : 4'b0011;
        lane.data = wdata << {off[1], 4'b0000};
      end
      MT_W:    lane.be = 4'b1111;
      default: lane.be = 4'b0000;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// Load extraction: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it according to the load type.
module dmem_responder_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  mem_type_e   kind_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[{off_i, 3'b000} +: 8];
    sel_half = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (kind_i)
      MT_LDB:  data_o = {{24{sel_byte[7]}}, sel_byte};
      MT_LDBU: data_o = {24'h000000, sel_byte};
      MT_LDH:  data_o = {{16{sel_half[15]}}, sel_half};
      MT_LDHU: data_o = {16'h0000, sel_half};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a one-slot load response pipeline, byte-lane
// stores, misalignment reporting and branch-flush kill of pending loads.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        misalign
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};
  logic [31:0] rd_word_q;

  resp_state_e state_q;
  logic        resp_valid_q;
  logic        misalign_q;
  logic [31:0] hold_q;
  mem_type_e   type_q;
  logic [1:0]  off_q;

  mem_type_e         req_kind;
  logic [ADDR_W-1:0] word_idx;
  logic              req_mis;
  logic              accept;
  logic              ld_acc;
  logic              st_acc;
  logic              rd_en;
  store_lane_t       lane;
  logic [31:0]       src_word;
  logic [31:0]       aligned;
  logic              unused_addr_hi;

  assign req_kind       = mem_type_e'(req_type);
  assign word_idx       = req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign req_mis        = is_misaligned(req_kind, req_addr[1:0]);

  assign req_ready = !resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;
  assign ld_acc    = accept & !req_we & is_load_type(req_kind) & !req_mis;
  assign st_acc    = accept & req_we & is_store_type(req_kind) & !req_mis;
  assign rd_en     = ld_acc & !flush;
  assign lane      = store_lane(req_kind, req_addr[1:0], req_wdata);

  // One request per cycle, so the single port never sees a read and a write
  // together; a load right after a store therefore reads the updated word.
  always_ff @(posedge clk) begin
    if (st_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (lane.be[b]) mem_q[word_idx][8*b +: 8] <= lane.data[8*b +: 8];
      end
    end
    if (rd_en) rd_word_q <= mem_q[word_idx];
  end

  // Response FSM: RESP serves the RAM output register, HOLD serves a copy
  // taken when the consumer stalls so the read port stays idle meanwhile.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      hold_q       <= '0;
      type_q       <= MT_NOP;
      off_q        <= 2'b00;
    end else begin
      misalign_q <= accept & req_mis &
                    ((req_we & is_store_type(req_kind)) | (!req_we & is_load_type(req_kind)));
      if (rd_en) begin
        type_q <= req_kind;
        off_q  <= req_addr[1:0];
      end
      if (flush) begin
        state_q      <= ST_IDLE;
        resp_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ld_acc) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
          ST_RESP: begin
            if (!resp_ready) begin
              state_q <= ST_HOLD;
              hold_q  <= rd_word_q;
            end else if (ld_acc) begin
              state_q <= ST_RESP;
            end else begin
              state_q      <= ST_IDLE;
              resp_valid_q <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (resp_ready) begin
              if (ld_acc) begin
                state_q <= ST_RESP;
              end else begin
                state_q      <= ST_IDLE;
                resp_valid_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign src_word = (state_q == ST_HOLD) ? hold_q : rd_word_q;

  dmem_responder_load_align u_load_align (
    .word_i (src_word),
    .kind_i (type_q),
    .off_i  (off_q),
    .data_o (aligned)
  );

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_valid_q ? aligned : 32'h0000_0000;
  assign misalign   = misalign_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 12: word-address width; memory depth is 2^ADDR_W words of 32 bits.
REQ-002 Parameter INIT_ZERO, default 1: when 1, all memory words are 0 after power-up (simulation init).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_type  input  3  mem_type code (shared package).
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  unshifted store data (low bits significant).
REQ-012 flush  input  1  branch-correction kill of any in-flight load response.
REQ-013 resp_valid  output  1  load data available.
REQ-014 resp_ready  input  1  consumer takes response.
REQ-015 resp_rdata  output  32  aligned, extended load data.
REQ-016 misalign  output  1  one-cycle pulse: accepted request was misaligned.

Function
REQ-017 mem_type codes SHALL be: 001 W, 010 LD.B, 011 LD.H, 100 LD.BU, 101 LD.HU, 110 ST.B, 111 ST.H; other codes are no-ops.
REQ-018 req_ready SHALL equal !resp_valid | resp_ready (single-slot response pipeline).
REQ-019 Accepted store SHALL write memory word req_addr[ADDR_W+1:2] in the accept cycle with byte enables: ST.B -> 0001<<addr[1:0], data<<8*addr[1:0]; ST.H -> 0011 or 1100 by addr[1], data<<16*addr[1]; W -> 1111; stores produce no response.
REQ-020 Accepted load SHALL perform a synchronous read; resp_valid rises the cycle after acceptance (latency 1).
REQ-021 Response extraction: LD.B/BU select byte addr[1:0]; LD.H/HU select half addr[1]; B/H sign-extend bit 7/15, BU/HU zero-extend; W passes word.
REQ-022 Stall hold: while resp_valid & !resp_ready, resp_rdata SHALL remain constant; raw memory output SHALL be captured into a hold register and the read port not re-enabled.
REQ-023 Back-to-back loads with resp_ready=1 SHALL sustain one response per cycle.
REQ-024 Load accepted the cycle after a store to the same word SHALL return post-store data.
REQ-025 Misaligned request (H with addr[0]=1, W with addr[1:0]!=0) SHALL be accepted, pulse misalign, perform no write, produce no response.
REQ-026 flush SHALL clear resp_valid next edge and drop any load accepted in the same cycle; flush overrides resp_ready; stores accepted in that cycle still write.
REQ-027 FSM states: IDLE (no response), RESP (fresh BRAM data valid), HOLD (data from hold register); IDLE->RESP on load accept; RESP->RESP on consume+new load; RESP->IDLE on consume, no load; RESP->HOLD on !resp_ready; HOLD->RESP/IDLE on consume with/without new load; any->IDLE on flush.
REQ-028 Address bits above ADDR_W+1 SHALL be ignored (wrap-around aliasing).

Reset
REQ-029 On rstn low: state IDLE, resp_valid 0, resp_rdata 0, misalign 0, hold register 0; memory contents not cleared.
REQ-030 Reset asserted mid-response SHALL discard the response; first cycle after release req_ready=1.

Structure
REQ-031 mem_type codes and FSM state enum SHALL live in the shared pipeline package.
REQ-032 One sub-module load_align (combinational extraction/extension, REQ-021) SHALL be instantiated; memory array inferred as single-port write-first RAM.

Verification
REQ-033 ST.W 0x11223344 @0x100, then LD.W @0x100 -> resp_rdata 0x11223344 one cycle after accept.
REQ-034 ST.B 0x80 @0x103, LD.B @0x103 -> 0xFFFFFF80; LD.BU -> 0x00000080; LD.W @0x100 -> 0x80223344.
REQ-035 ST.H 0xBEEF @0x202, LD.H @0x202 -> 0xFFFFBEEF; LD.HU -> 0x0000BEEF; LD.H @0x201 -> misalign pulse, no resp_valid.
REQ-036 Three back-to-back loads, resp_ready low 4 cycles on second response -> rdata stable, req_ready low, order preserved, no loss.
REQ-037 Load accepted with flush high -> resp_valid stays 0; store with flush high still visible to later load.
REQ-038 rstn low during HOLD -> resp_valid 0 next cycle, req_ready 1 after release, memory contents intact.
